// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin arbiter that owns the J/K pins of a shared
// JK flip-flop bank, drives one command per slot and verifies the result.
module jk_bank_sequencer #(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [2*N_REQ-1:0]     req_cmd,
   input  logic [WIDTH*N_REQ-1:0] req_mask,
   output logic [N_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]       j_out,
   output logic [WIDTH-1:0]       k_out,
   input  logic [WIDTH-1:0]       q_in,
   input  logic                   clr_err,
   output logic                   busy,
   output logic                   done,
   output logic [IDW-1:0]         grant_id,
   output logic                   err,
   output logic [IDW-1:0]         err_id
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      VERIFY
   } state_t;

   localparam logic [1:0] C_HOLD = 2'b00;
   localparam logic [1:0] C_CLR  = 2'b01;
   localparam logic [1:0] C_SET  = 2'b10;
   localparam logic [1:0] C_TGL  = 2'b11;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   err_id_q, err_id_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;

   logic             found;
   logic [IDW-1:0]   win;
   logic [1:0]       sel_cmd;
   logic [WIDTH-1:0] sel_mask;
   logic [N_REQ-1:0] ready;

   // First valid requester after the last grant, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr_q) + k) % N_REQ);
         end
      end
   end

   assign sel_cmd  = req_cmd[2*win +: 2];
   assign sel_mask = req_mask[WIDTH*win +: WIDTH];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      exp_d    = exp_q;
      err_d    = err_q;
      err_id_d = err_id_q;
      j_d      = '0;
      k_d      = '0;
      ready    = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               ready[win] = 1'b1;
               ptr_d      = win;
               grant_d    = win;
               state_d    = DRIVE;
               unique case (sel_cmd)
                  C_CLR: begin
                     k_d   = sel_mask;
                     exp_d = q_in & ~sel_mask;
                  end
                  C_SET: begin
                     j_d   = sel_mask;
                     exp_d = q_in | sel_mask;
                  end
                  C_TGL: begin
                     j_d   = sel_mask;
                     k_d   = sel_mask;
                     exp_d = q_in ^ sel_mask;
                  end
                  C_HOLD: exp_d = q_in;
               endcase
            end
         end
         DRIVE:   state_d = VERIFY;
         VERIFY:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clr_err) begin
         err_d    = 1'b0;
         err_id_d = '0;
      end
      // A fresh mismatch takes priority over a clear in the same cycle.
      if (state_q == VERIFY && q_in != exp_q) begin
         err_d    = 1'b1;
         err_id_d = grant_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= IDW'(N_REQ - 1);
         grant_q  <= '0;
         exp_q    <= '0;
         err_q    <= 1'b0;
         err_id_q <= '0;
         j_q      <= '0;
         k_q      <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         exp_q    <= exp_d;
         err_q    <= err_d;
         err_id_q <= err_id_d;
         j_q      <= j_d;
         k_q      <= k_d;
      end
   end

   assign req_ready = ready;
   assign j_out     = j_q;
   assign k_out     = k_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == VERIFY);
   assign grant_id  = grant_q;
   assign err       = err_q;
   assign err_id    = err_id_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK bank
// and an optional stuck-at-0 fault on bank bit 0.
module tb_jk_bank_sequencer;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [2*N-1:0] req_cmd = '0;
   logic [W*N-1:0] req_mask = '0;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   j_out, k_out, q_in;
   logic           clr_err = 1'b0;
   logic           busy, done, err;
   logic [1:0]     grant_id, err_id;

   logic [W-1:0]   bank_q = '0;
   logic           load_en = 1'b0;
   logic [W-1:0]   load_val = '0;
   logic           stuck = 1'b0;

   int errors = 0;
   int checks = 0;

   jk_bank_sequencer #(.N_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_cmd(req_cmd),
      .req_mask(req_mask), .req_ready(req_ready),
      .j_out(j_out), .k_out(k_out), .q_in(q_in),
      .clr_err(clr_err), .busy(busy), .done(done),
      .grant_id(grant_id), .err(err), .err_id(err_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en) bank_q <= load_val;
      else begin
         for (int b = 0; b < W; b++) begin
            case ({j_out[b], k_out[b]})
               2'b10:   bank_q[b] <= 1'b1;
               2'b01:   bank_q[b] <= 1'b0;
               2'b11:   bank_q[b] <= ~bank_q[b];
               default: bank_q[b] <= bank_q[b];
            endcase
         end
      end
   end

   assign q_in = bank_q & ~{{(W-1){1'b0}}, stuck};

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic load_bank(input logic [W-1:0] v);
      load_en = 1'b1;
      load_val = v;
      step();
      load_en = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [1:0] c, input logic [W-1:0] m);
      req_cmd[2*i +: 2] = c;
      req_mask[W*i +: W] = m;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({j_out, k_out} !== '0) begin
         errors++; $display("FAIL reset_jk: got %h/%h want 00/00", j_out, k_out);
      end
      checks++;
      if ({busy, done, err, req_ready} !== '0) begin
         errors++; $display("FAIL reset_ctl: busy=%b done=%b err=%b ready=%b want 0", busy, done, err, req_ready);
      end
      checks++;
      if (grant_id !== 2'd0 || err_id !== 2'd0) begin
         errors++; $display("FAIL reset_ids: grant=%0d err_id=%0d want 0/0", grant_id, err_id);
      end
   endtask

   task automatic test_basic_set();
      load_bank(8'h00);
      set_req(0, 2'b10, 8'h0F);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL basic_ready: got %b want 0001", req_ready);
      end
      step();
      req_valid = '0;
      checks++;
      if (j_out !== 8'h0F || k_out !== 8'h00 || busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL basic_drive: j=%h k=%h busy=%b done=%b want 0f 00 1 0", j_out, k_out, busy, done);
      end
      step();
      checks++;
      if (q_in !== 8'h0F || done !== 1'b1 || busy !== 1'b1 || {j_out, k_out} !== '0) begin
         errors++; $display("FAIL basic_verify: q=%h done=%b busy=%b jk=%h want 0f 1 1 0", q_in, done, busy, {j_out, k_out});
      end
      step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || grant_id !== 2'd0) begin
         errors++; $display("FAIL basic_end: err=%b busy=%b done=%b grant=%0d want 0 0 0 0", err, busy, done, grant_id);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] want;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 2'b00, 8'hFF);
      req_valid = 4'hF;
      for (int s = 0; s < 12; s++) begin
         want = 4'b0001 << (s % N);
         #1;
         checks++;
         if (req_ready !== want) begin
            errors++; $display("FAIL rot_ready[%0d]: got %b want %b", s, req_ready, want);
         end
         step();
         checks++;
         if (grant_id !== 2'(s % N) || req_ready !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL rot_grant[%0d]: grant=%0d ready=%b busy=%b want %0d 0 1", s, grant_id, req_ready, busy, s % N);
         end
         step();
         checks++;
         if (req_ready !== '0 || done !== 1'b1) begin
            errors++; $display("FAIL rot_verify[%0d]: ready=%b done=%b want 0 1", s, req_ready, done);
         end
         step();
      end
      req_valid = '0;
   endtask

   task automatic test_back_to_back();
      load_bank(8'hA5);
      set_req(2, 2'b11, 8'hFF);
      set_req(3, 2'b01, 8'hF0);
      req_valid = 4'b1100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL b2b_first: ready=%b want 0100", req_ready);
      end
      step();
      req_valid = 4'b1000;
      step();
      checks++;
      if (q_in !== 8'h5A || done !== 1'b1) begin
         errors++; $display("FAIL b2b_tgl: q=%h done=%b want 5a 1", q_in, done);
      end
      step();
      checks++;
      if (req_ready !== 4'b1000 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_second: ready=%b done=%b want 1000 0", req_ready, done);
      end
      step();
      req_valid = '0;
      checks++;
      if (j_out !== 8'h00 || k_out !== 8'hF0) begin
         errors++; $display("FAIL b2b_clr_drive: j=%h k=%h want 00 f0", j_out, k_out);
      end
      step();
      checks++;
      if (q_in !== 8'h0A || done !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL b2b_clr: q=%h done=%b err=%b want 0a 1 0", q_in, done, err);
      end
      step();
   endtask

   task automatic test_error();
      load_bank(8'h00);
      stuck = 1'b1;
      set_req(1, 2'b10, 8'h01);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      step();
      step();
      checks++;
      if (err !== 1'b1 || err_id !== 2'd1) begin
         errors++; $display("FAIL err_set: err=%b err_id=%0d want 1 1", err, err_id);
      end
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      checks++;
      if (err !== 1'b1 || err_id !== 2'd1) begin
         errors++; $display("FAIL err_clr_race: err=%b err_id=%0d want 1 1", err, err_id);
      end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      checks++;
      if (err !== 1'b0 || err_id !== 2'd0) begin
         errors++; $display("FAIL err_clr: err=%b err_id=%0d want 0 0", err, err_id);
      end
      stuck = 1'b0;
   endtask

   task automatic test_reset_mid();
      load_bank(8'h3C);
      set_req(0, 2'b11, 8'hFF);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      checks++;
      if (j_out !== 8'hFF || k_out !== 8'hFF) begin
         errors++; $display("FAIL mid_drive: j=%h k=%h want ff ff", j_out, k_out);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({j_out, k_out} !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL mid_async: jk=%h busy=%b done=%b err=%b want 0", {j_out, k_out}, busy, done, err);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (done !== 1'b0 || q_in !== 8'h3C) begin
         errors++; $display("FAIL mid_drop: done=%b q=%h want 0 3c", done, q_in);
      end
      set_req(2, 2'b00, 8'h00);
      set_req(0, 2'b00, 8'h00);
      req_valid = 4'b0101;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL mid_restart: ready=%b want 0001", req_ready);
      end
      step();
      req_valid = '0;
      step();
      step();
   endtask

   task automatic test_hold_zero();
      logic [1:0] cmds [2];
      logic [W-1:0] masks [2];
      cmds[0] = 2'b00; masks[0] = 8'hFF;
      cmds[1] = 2'b10; masks[1] = 8'h00;
      load_bank(8'h96);
      for (int t = 0; t < 2; t++) begin
         set_req(3, cmds[t], masks[t]);
         req_valid = 4'b1000;
         step();
         req_valid = '0;
         checks++;
         if ({j_out, k_out} !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL hz_drive[%0d]: jk=%h busy=%b want 0 1", t, {j_out, k_out}, busy);
         end
         step();
         checks++;
         if (done !== 1'b1 || q_in !== 8'h96) begin
            errors++; $display("FAIL hz_verify[%0d]: done=%b q=%h want 1 96", t, done, q_in);
         end
         step();
         checks++;
         if (err !== 1'b0 || grant_id !== 2'd3) begin
            errors++; $display("FAIL hz_end[%0d]: err=%b grant=%0d want 0 3", t, err, grant_id);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_set();
      test_rotation();
      test_back_to_back();
      test_error();
      test_reset_mid();
      test_hold_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Round-robin controller that shares one bank of JK flip-flops among several requesters. Each requester issues a per-bit command (hold / clear / set / toggle) under a bit mask. The block arbitrates and drives the bank's J/K inputs for exactly one clock, then checks the bank outputs against the expected result. It is the only driver of the bank's J/K pins.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: number of JK flip-flops in the bank.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  N_REQ: request pending, one bit per requester.
- `req_cmd`  in  2*N_REQ: command of requester i in bits [2i+1:2i]. 00 hold, 01 clear, 10 set, 11 toggle.
- `req_mask`  in  WIDTH*N_REQ: bit mask of requester i in bits [WIDTH*i+WIDTH-1:WIDTH*i].
- `req_ready`  out  N_REQ: accept strobe, one-hot or zero.
- `j_out`  out  WIDTH: J inputs of the bank, registered.
- `k_out`  out  WIDTH: K inputs of the bank, registered.
- `q_in`  in  WIDTH: Q outputs of the bank.
- `clr_err`  in  1: synchronous clear of the sticky error.
- `busy`  out  1: high in DRIVE and VERIFY.
- `done`  out  1: one-cycle pulse at the end of VERIFY.
- `grant_id`  out  clog2(N_REQ): index of the last accepted requester.
- `err`  out  1: sticky; set when bank Q differs from the expected value.
- `err_id`  out  clog2(N_REQ): requester whose command caused the latest error.

## Operation
- FSM states: IDLE, DRIVE, VERIFY.
- **IDLE**
  - If any `req_valid` is high, select the winner by round-robin. Search starts at `ptr+1` modulo N_REQ, where `ptr` is the last granted index.
  - Assert `req_ready[winner]` combinationally in this cycle. The handshake completes on the rising edge.
  - At that edge:
    - capture cmd and mask;
    - `ptr`, `grant_id` <= winner;
    - `expected` <= `q_in` with masked bits cleared, set or inverted per cmd (unchanged for hold or zero mask);
    - go to DRIVE.
  - With no valid request, stay in IDLE; `req_ready` = 0.
- **DRIVE**
  - `j_out`/`k_out` hold the captured command:
    - clear: J=0, K=mask;
    - set: J=mask, K=0;
    - toggle: J=K=mask;
    - hold: J=K=0.
  - The bank samples these on the edge that ends DRIVE. Next state is VERIFY.
- **VERIFY**
  - `j_out` = `k_out` = 0.
  - Compare `q_in` with `expected`. On mismatch, at the edge: `err` <= 1 and `err_id` <= `grant_id`.
  - `done` = 1 for this cycle. Next state is IDLE.
- Hold commands and zero masks still consume a full slot and produce `done`.
- `req_valid` changing outside IDLE is ignored. A requester keeps `req_valid` high until it sees `req_ready`.
- `clr_err` clears `err` and `err_id` at the edge. A mismatch in the same cycle wins: `err` stays 1.
- All bits are independent. Unmasked bits always get J=K=0.

## Timing
- Reset values: state IDLE, `ptr` = N_REQ-1 (requester 0 wins first), `j_out` = `k_out` = 0, `req_ready` = 0, `busy` = 0, `done` = 0, `grant_id` = 0, `err` = 0, `err_id` = 0.
- Acceptance in cycle t (IDLE, `req_ready` high) gives:
  - t+1: DRIVE; J/K valid; `busy` = 1.
  - End of t+1: bank updates.
  - t+2: VERIFY; `done` = 1; `busy` = 1.
  - t+3: IDLE; next acceptance is possible.
- Throughput is one command per 3 cycles. `req_ready` is never high outside IDLE.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0. A requester waits at most N_REQ-1 slots (3·(N_REQ-1) cycles).
- Reset asserted mid-operation:
  - J/K are forced to 0 immediately (asynchronous);
  - the in-flight command is dropped with no `done`;
  - `err` is cleared;
  - after release, arbitration restarts from requester 0.

## Test plan
- Reset, then requester 0 issues set, mask 0x0F, bank at 0x00 → `req_ready[0]` in cycle t; J=0x0F, K=0x00 in t+1; `q_in` = 0x0F and `done` = 1 in t+2; `err` = 0.
- All 4 requesters valid continuously, 12 commands → `grant_id` sequence 0,1,2,3,0,1,2,3,0,1,2,3; exactly one `req_ready` per slot, every third cycle.
- Bank at 0xA5; requester 2 issues toggle, mask 0xFF, then requester 3 issues clear, mask 0xF0 → 0x5A, then 0x0A; `done` pulses 3 cycles apart.
- Bench forces `q_in` bit 0 stuck at 0 during a set with mask 0x01 from requester 1 → `err` = 1 and `err_id` = 1 after VERIFY. `clr_err` asserted in the same cycle as a new mismatch → `err` stays 1. `clr_err` alone → `err` = 0.
- `rst_n` pulsed low during DRIVE of a toggle → `j_out` = `k_out` = 0 immediately, no `done`, `busy` = 0. After release with requesters 2 and 0 valid, requester 0 is granted first.
- Hold command, and set with mask 0x00 → J=K=0 in DRIVE, bank unchanged, `done` pulses, `err` = 0.
